// File: rtl/iob2axil.sv
// rtl/iob2axil.sv - IOb slave to AXI4-Lite master bridge, one transaction outstanding
module iob2axil #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]          axil_awprot_o,
  output logic                axil_awvalid_o,
  input  logic                axil_awready_i,
  output logic [DATA_W-1:0]   axil_wdata_o,
  output logic [DATA_W/8-1:0] axil_wstrb_o,
  output logic                axil_wvalid_o,
  input  logic                axil_wready_i,
  input  logic [1:0]          axil_bresp_i,
  input  logic                axil_bvalid_i,
  output logic                axil_bready_o,
  output logic [ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]          axil_arprot_o,
  output logic                axil_arvalid_o,
  input  logic                axil_arready_i,
  input  logic [DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]          axil_rresp_i,
  input  logic                axil_rvalid_i,
  output logic                axil_rready_o
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                aw_done;
  logic                w_done;
  logic                aw_hs;
  logic                w_hs;

  assign aw_hs = axil_awvalid_o & axil_awready_i;
  assign w_hs  = axil_wvalid_o & axil_wready_i;

  assign iob_ready_o   = (state == IDLE);
  assign axil_bready_o = (state == WR_RESP);
  assign axil_rready_o = (state == RD_RESP);

  assign axil_awaddr_o = addr_q;
  assign axil_araddr_o = addr_q;
  assign axil_wdata_o  = wdata_q;
  assign axil_wstrb_o  = wstrb_q;
  assign axil_awprot_o = 3'b000;
  assign axil_arprot_o = 3'b000;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state          <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      axil_awvalid_o <= 1'b0;
      axil_wvalid_o  <= 1'b0;
      axil_arvalid_o <= 1'b0;
      iob_rvalid_o   <= 1'b0;
      iob_rdata_o    <= '0;
      err_o          <= 1'b0;
    end else if (cke_i) begin
      iob_rvalid_o <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (iob_avalid_i) begin
            addr_q  <= iob_addr_i;
            wdata_q <= iob_wdata_i;
            wstrb_q <= iob_wstrb_i;
            if (|iob_wstrb_i) begin
              axil_awvalid_o <= 1'b1;
              axil_wvalid_o  <= 1'b1;
              state          <= WR_REQ;
            end else begin
              axil_arvalid_o <= 1'b1;
              state          <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            axil_awvalid_o <= 1'b0;
            aw_done        <= 1'b1;
          end
          if (w_hs) begin
            axil_wvalid_o <= 1'b0;
            w_done        <= 1'b1;
          end
          // AW and W may finish in either order; a handshake this cycle counts as done
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axil_bvalid_i) begin
            err_o <= |axil_bresp_i;
            state <= IDLE;
          end
        end
        RD_REQ: begin
          if (axil_arready_i) begin
            axil_arvalid_o <= 1'b0;
            state          <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (axil_rvalid_i) begin
            iob_rdata_o  <= axil_rdata_i;
            iob_rvalid_o <= 1'b1;
            err_o        <= |axil_rresp_i;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob2axil.sv
// tb/tb_iob2axil.sv - self-checking bench for iob2axil with an AXI-Lite slave model and scoreboard
module tb_iob2axil;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arst_n_i = 1'b0;
  logic          cke_i = 1'b1;
  logic          iob_avalid_i = 1'b0;
  logic [AW-1:0] iob_addr_i = '0;
  logic [DW-1:0] iob_wdata_i = '0;
  logic [3:0]    iob_wstrb_i = '0;
  logic          iob_ready_o, iob_rvalid_o, err_o;
  logic [DW-1:0] iob_rdata_o;
  logic [AW-1:0] axil_awaddr_o, axil_araddr_o;
  logic [2:0]    axil_awprot_o, axil_arprot_o;
  logic          axil_awvalid_o, axil_wvalid_o, axil_bready_o, axil_arvalid_o, axil_rready_o;
  logic [DW-1:0] axil_wdata_o;
  logic [3:0]    axil_wstrb_o;
  logic          axil_awready_i = 0, axil_wready_i = 0, axil_bvalid_i = 0;
  logic          axil_arready_i = 0, axil_rvalid_i = 0;
  logic [1:0]    axil_bresp_i = 0, axil_rresp_i = 0;
  logic [DW-1:0] axil_rdata_i = 0;

  always #5 clk = ~clk;

  iob2axil #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .cke_i(cke_i),
    .iob_avalid_i(iob_avalid_i), .iob_addr_i(iob_addr_i), .iob_wdata_i(iob_wdata_i),
    .iob_wstrb_i(iob_wstrb_i), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
    .iob_rdata_o(iob_rdata_o), .err_o(err_o),
    .axil_awaddr_o(axil_awaddr_o), .axil_awprot_o(axil_awprot_o), .axil_awvalid_o(axil_awvalid_o),
    .axil_awready_i(axil_awready_i), .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o),
    .axil_wvalid_o(axil_wvalid_o), .axil_wready_i(axil_wready_i), .axil_bresp_i(axil_bresp_i),
    .axil_bvalid_i(axil_bvalid_i), .axil_bready_o(axil_bready_o), .axil_araddr_o(axil_araddr_o),
    .axil_arprot_o(axil_arprot_o), .axil_arvalid_o(axil_arvalid_o), .axil_arready_i(axil_arready_i),
    .axil_rdata_i(axil_rdata_i), .axil_rresp_i(axil_rresp_i), .axil_rvalid_i(axil_rvalid_i),
    .axil_rready_o(axil_rready_o)
  );

  wire [39:0] out_vec = {iob_ready_o, iob_rvalid_o, err_o, axil_arvalid_o, axil_rready_o,
                         axil_awvalid_o, axil_wvalid_o, axil_bready_o, iob_rdata_o};

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboards: reads hold {err, data}, writes hold expected err
  logic [32:0] rq[$];
  bit          wq[$];
  logic [32:0] rexp;
  bit          wexp;
  int acc_cnt = 0;
  int br_cnt = 0;

  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  logic [1:0]  bresp_cfg = 0, rresp_cfg = 0;
  logic [31:0] rdata_cfg = 0, ar_addr_m = 0;
  bit          rd_use_cfg = 0;
  bit cke_prev = 0, b_pend = 0;
  bit p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0, p_arv = 0, p_arhs = 0;
  logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;

  // monitor, protocol checks and slave model; inputs change here and stay stable through the next posedge
  always @(negedge clk) begin
    if (!arst_n_i) begin
      axil_awready_i = 0; axil_wready_i = 0; axil_bvalid_i = 0;
      axil_arready_i = 0; axil_rvalid_i = 0;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      b_pend = 0; p_awv = 0; p_wv = 0; p_arv = 0;
      cke_prev = cke_i;
    end else begin
      if (p_awv && !p_awhs) begin
        check("aw_hold", axil_awvalid_o, 1);
        check("awaddr_stable", axil_awaddr_o, p_awaddr);
      end
      if (p_wv && !p_whs) begin
        check("w_hold", axil_wvalid_o, 1);
        check("wdata_stable", axil_wdata_o, p_wdata);
      end
      if (p_arv && !p_arhs) begin
        check("ar_hold", axil_arvalid_o, 1);
        check("araddr_stable", axil_araddr_o, p_araddr);
      end
      if (b_pend) begin
        if (wq.size() == 0) check("b_unexpected", wq.size(), 1);
        else begin
          wexp = wq.pop_front();
          check("b_err", err_o, wexp);
          check("wr_no_rvalid", iob_rvalid_o, 0);
        end
      end else if (cke_prev && iob_rvalid_o) begin
        if (rq.size() == 0) check("r_unexpected", rq.size(), 1);
        else begin
          rexp = rq.pop_front();
          check("rdata", iob_rdata_o, rexp[31:0]);
          check("r_err", err_o, rexp[32]);
        end
      end else if (cke_prev && err_o) begin
        check("orphan_err", err_o, 0);
      end

      if (axil_awready_i) begin
        if (cke_prev) axil_awready_i = 0;
      end else if (axil_awvalid_o) begin
        if (aw_c >= aw_dly) begin axil_awready_i = 1; aw_c = 0; end else aw_c++;
      end
      if (axil_wready_i) begin
        if (cke_prev) axil_wready_i = 0;
      end else if (axil_wvalid_o) begin
        if (w_c >= w_dly) begin axil_wready_i = 1; w_c = 0; end else w_c++;
      end
      if (axil_bvalid_i) begin
        if (cke_prev) axil_bvalid_i = 0;
      end else if (axil_bready_o) begin
        if (b_c >= b_dly) begin axil_bvalid_i = 1; axil_bresp_i = bresp_cfg; b_c = 0; end else b_c++;
      end
      if (axil_arready_i) begin
        if (cke_prev) axil_arready_i = 0;
      end else if (axil_arvalid_o) begin
        if (ar_c >= ar_dly) begin axil_arready_i = 1; ar_c = 0; end else ar_c++;
      end
      if (axil_rvalid_i) begin
        if (cke_prev) axil_rvalid_i = 0;
      end else if (axil_rready_o) begin
        if (r_c >= r_dly) begin
          axil_rvalid_i = 1;
          axil_rresp_i  = rresp_cfg;
          axil_rdata_i  = rd_use_cfg ? rdata_cfg : (ar_addr_m ^ 32'h5A5A0000);
          r_c = 0;
        end else r_c++;
      end

      p_awv = axil_awvalid_o; p_awhs = axil_awvalid_o & axil_awready_i & cke_i; p_awaddr = axil_awaddr_o;
      p_wv = axil_wvalid_o;   p_whs = axil_wvalid_o & axil_wready_i & cke_i;    p_wdata = axil_wdata_o;
      p_arv = axil_arvalid_o; p_arhs = axil_arvalid_o & axil_arready_i & cke_i; p_araddr = axil_araddr_o;
      if (p_arhs) ar_addr_m = axil_araddr_o;
      b_pend = axil_bvalid_i & axil_bready_o & cke_i;
      if (iob_avalid_i && iob_ready_o && cke_i) acc_cnt++;
      if (axil_bready_o) br_cnt++;
      cke_prev = cke_i;
    end
  end

  task automatic rst_checks();
    check("rst_iob", {iob_ready_o, iob_rvalid_o, err_o}, 3'b100);
    check("rst_axi_valids", {axil_awvalid_o, axil_wvalid_o, axil_arvalid_o, axil_bready_o, axil_rready_o}, 0);
    check("rst_awaddr", axil_awaddr_o, 0);
    check("rst_araddr", axil_araddr_o, 0);
    check("rst_wdata", axil_wdata_o, 0);
    check("rst_wstrb", axil_wstrb_o, 0);
    check("rst_rdata", iob_rdata_o, 0);
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output int lat, output int wt, output logic rv);
    bit ok;
    @(posedge clk); #2;
    iob_avalid_i = 1; iob_addr_i = a; iob_wdata_i = d; iob_wstrb_i = s;
    wt = 0; ok = 0;
    while (!ok && wt < 100) begin @(negedge clk); wt++; ok = iob_ready_o && cke_i; end
    check("req_accept", ok, 1);
    @(posedge clk); #2;
    iob_avalid_i = 0;
    lat = 0; ok = 0;
    while (!ok && lat < 100) begin @(negedge clk); lat++; ok = iob_ready_o; end
    rv = iob_rvalid_o;
  endtask

  initial begin
    int lat, wt, br0, acc0;
    logic rv;
    bit ok;
    logic [39:0] snap;

    #12;
    rst_checks();
    @(posedge clk); #2;
    arst_n_i = 1;

    // single write, zero-wait slave
    wq.push_back(1'b0);
    @(posedge clk); #2;
    iob_avalid_i = 1; iob_addr_i = 32'h100; iob_wdata_i = 32'hDEADBEEF; iob_wstrb_i = 4'hF;
    @(negedge clk);
    check("wr_accept_ready", iob_ready_o, 1);
    @(posedge clk); #2;
    iob_avalid_i = 0;
    @(negedge clk);
    check("wr_c1_valids", {axil_awvalid_o, axil_wvalid_o, iob_ready_o}, 3'b110);
    check("wr_c1_awaddr", axil_awaddr_o, 32'h100);
    check("wr_c1_wdata", axil_wdata_o, 32'hDEADBEEF);
    check("wr_c1_wstrb", axil_wstrb_o, 4'hF);
    check("wr_prot", {axil_awprot_o, axil_arprot_o}, 0);
    @(negedge clk);
    check("wr_c2_bready", {axil_bready_o, axil_awvalid_o, axil_wvalid_o}, 3'b100);
    @(negedge clk);
    check("wr_c3_ready", {iob_ready_o, iob_rvalid_o, err_o}, 3'b100);

    // single read
    rd_use_cfg = 1; rdata_cfg = 32'h12345678;
    rq.push_back({1'b0, 32'h12345678});
    req(32'h204, 0, 4'h0, lat, wt, rv);
    check("rd_latency", lat, 3);
    check("rd_rvalid_c3", rv, 1);

    // skewed write channels, both orders
    aw_dly = 4; w_dly = 0;
    wq.push_back(1'b0); br0 = br_cnt;
    req(32'h108, 32'hCAFEF00D, 4'h3, lat, wt, rv);
    check("skew_aw_latency", lat, 7);
    check("skew_aw_bwait", br_cnt - br0, 1);
    check("skew_aw_no_rvalid", rv, 0);
    aw_dly = 0; w_dly = 4;
    wq.push_back(1'b0); br0 = br_cnt;
    req(32'h10C, 32'h0BADF00D, 4'hC, lat, wt, rv);
    check("skew_w_latency", lat, 7);
    check("skew_w_bwait", br_cnt - br0, 1);
    w_dly = 0;

    // error responses
    bresp_cfg = 2'b10;
    wq.push_back(1'b1);
    req(32'h110, 32'h1, 4'hF, lat, wt, rv);
    check("berr_latency", lat, 3);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b11; rdata_cfg = 32'hA5A5A5A5;
    rq.push_back({1'b1, 32'hA5A5A5A5});
    req(32'h208, 0, 4'h0, lat, wt, rv);
    check("rerr_rvalid", rv, 1);
    rresp_cfg = 2'b00; rd_use_cfg = 0;

    // held avalid across three reads, slow R channel, clock-enable freeze
    r_dly = 5; acc0 = acc_cnt;
    @(posedge clk); #2;
    iob_avalid_i = 1; iob_wstrb_i = 4'h0; iob_addr_i = 32'h300;
    for (int i = 0; i < 3; i++) begin
      ok = 0;
      for (int k = 0; k < 100 && !ok; k++) begin @(negedge clk); ok = iob_ready_o && cke_i; end
      check("bp_accept", ok, 1);
      rq.push_back({1'b0, iob_addr_i ^ 32'h5A5A0000});
      @(posedge clk); #2;
      if (i == 2) iob_avalid_i = 0;
      else iob_addr_i = iob_addr_i + 4;
      if (i == 1) begin
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin @(negedge clk); ok = axil_rready_o; end
        check("bp_rd_resp_reached", ok, 1);
        @(posedge clk); #2;
        cke_i = 0;
        snap = out_vec;
        @(negedge clk);
        check("cke_freeze_1", out_vec, snap);
        @(posedge clk); #2;
        cke_i = 1;
        check("cke_freeze_2", out_vec, snap);
      end
    end
    for (int k = 0; k < 200 && rq.size() != 0; k++) @(negedge clk);
    check("bp_drain", rq.size(), 0);
    check("bp_accept_count", acc_cnt - acc0, 3);
    r_dly = 0;

    // reset during WR_RESP, then an immediate read
    b_dly = 3;
    @(posedge clk); #2;
    iob_avalid_i = 1; iob_addr_i = 32'h1F0; iob_wdata_i = 32'h11223344; iob_wstrb_i = 4'hF;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin @(negedge clk); ok = iob_ready_o; end
    @(posedge clk); #2;
    iob_avalid_i = 0;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin @(negedge clk); ok = axil_bready_o; end
    check("rstw_reached_bresp", ok, 1);
    #1 arst_n_i = 0;
    #1 rst_checks();
    @(posedge clk); #2;
    arst_n_i = 1;
    b_dly = 0;
    rq.push_back({1'b0, 32'h40C ^ 32'h5A5A0000});
    req(32'h40C, 0, 4'h0, lat, wt, rv);
    check("post_rst_accept_first", wt, 1);
    check("post_rst_rd_latency", lat, 3);

    @(negedge clk);
    @(negedge clk);
    check("final_rq_empty", rq.size(), 0);
    check("final_wq_empty", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
